sevenseg_capture: RTL and testbench

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

---
 rtl/sevenseg_capture.sv | 176 +++++++++++++++++
 tb/tb_sevenseg_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - captures a multiplexed seven-segment display scan into a 16-bit frame
//
// Watches the segment and anode lines of a time-multiplexed 4-digit display.
// A digit is accepted once its segment/anode sample has been identical for
// STABLE_CYCLES consecutive samples. After all four digits are captured, the
// frame is published.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   segments     segment lines, bit6=a ... bit0=g
//   anode        digit enables, bit i selects digit i (one-hot when valid)
//   value        last complete frame, digit i in bits 4i+3:4i
//   frame_valid  one-cycle pulse when value/blank_mask update
//   blank_mask   bit i set when digit i was blank in the last frame
//   pattern_err  sticky: unknown segment pattern or non-one-hot anode seen
//
// Build option:
//   SEVENSEG_CAPTURE_ACTIVE_LOW_EN  invert segments and anode at the sample
//                                   stage (common-anode displays)

module sevenseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [3:0]  anode,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  blank_mask,
  output logic        pattern_err
);

  localparam logic       ST_SETTLE = 1'b0;
  localparam logic       ST_HELD   = 1'b1;
  localparam logic [7:0] STABLE_N  = 8'(STABLE_CYCLES);

  // seg_s/an_s: sample stage; seg_p/an_p: the sample before it
  logic [6:0]  seg_s;
  logic [6:0]  seg_p;
  logic [3:0]  an_s;
  logic [3:0]  an_p;
  logic        state;
  logic [7:0]  cnt;
  logic [15:0] stage_val;
  logic [3:0]  stage_blank;
  logic [3:0]  stage_mask;

  logic        dec_known;
  logic        dec_blank;
  logic [3:0]  dec_nib;
  logic [1:0]  dig_idx;
  logic        an_onehot;
  logic        changed;
  logic [7:0]  reload;
  logic        at_target;
  logic        capture;
  logic        bad;
  logic        frame_full;
  logic [3:0]  mask_base;
  logic [3:0]  cap_bit;

  // Decode the older sample: it is the value the counter has been counting.
  always_comb begin
    dec_known = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_p)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h73: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_known = 1'b0;
    endcase
  end

  always_comb begin
    an_onehot = 1'b1;
    dig_idx   = 2'd0;
    case (an_p)
      4'b0001: dig_idx = 2'd0;
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: an_onehot = 1'b0;
    endcase
  end

  assign changed    = (seg_s != seg_p) || (an_s != an_p);
  // A blanked (anode zero) sample never starts a run.
  assign reload     = (an_s == 4'h0) ? 8'd0 : 8'd1;
  assign at_target  = (state == ST_SETTLE) && (cnt == STABLE_N);
  assign capture    = at_target && an_onehot && dec_known;
  assign bad        = at_target && !(an_onehot && dec_known);
  assign frame_full = (stage_mask == 4'hF);
  // A capture on the frame-load edge lands in the freshly cleared mask.
  assign mask_base  = frame_full ? 4'h0 : stage_mask;
  assign cap_bit    = capture ? an_p : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s       <= 7'h00;
      seg_p       <= 7'h00;
      an_s        <= 4'h0;
      an_p        <= 4'h0;
      state       <= ST_SETTLE;
      cnt         <= 8'd0;
      stage_val   <= 16'h0000;
      stage_blank <= 4'h0;
      stage_mask  <= 4'h0;
      value       <= 16'h0000;
      blank_mask  <= 4'h0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
`ifdef SEVENSEG_CAPTURE_ACTIVE_LOW_EN
      seg_s <= ~segments;
      an_s  <= ~anode;
`else
      seg_s <= segments;
      an_s  <= anode;
`endif
      seg_p <= seg_s;
      an_p  <= an_s;

      if (state == ST_SETTLE) begin
        // A change on the capture edge keeps us settling on the new value,
        // while the stable digit just counted is still taken.
        if (changed) begin
          cnt <= reload;
        end else if (at_target) begin
          state <= ST_HELD;
        end else if (an_s == 4'h0) begin
          cnt <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else if (changed) begin
        state <= ST_SETTLE;
        cnt   <= reload;
      end

      if (bad) begin
        pattern_err <= 1'b1;
      end

      frame_valid <= 1'b0;
      if (frame_full) begin
        value       <= stage_val;
        blank_mask  <= stage_blank;
        frame_valid <= 1'b1;
      end

      if (capture) begin
        stage_val[{dig_idx, 2'b00} +: 4] <= dec_nib;
        stage_blank[dig_idx]             <= dec_blank;
      end
      stage_mask <= mask_base | cap_bit;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - self-checking bench for sevenseg_capture

module tb_sevenseg_capture;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  segments = 7'h00;
  logic [3:0]  anode = 4'h0;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  blank_mask;
  logic        pattern_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fvc = 0;
  int fv_cyc = -1;

  sevenseg_capture #(.STABLE_CYCLES(N)) dut (
    .clk(clk),
    .reset(reset),
    .segments(segments),
    .anode(anode),
    .value(value),
    .frame_valid(frame_valid),
    .blank_mask(blank_mask),
    .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  // Reference model: run lengths of identical input samples; a run reaching
  // N samples yields a capture/error two edges later (sample + compare).
  typedef struct {
    bit         valid;
    logic [6:0] seg;
    logic [3:0] an;
  } ev_t;

  logic [6:0] dig_tab [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  ev_t        m_q[$];
  logic [6:0] m_pseg;
  logic [3:0] m_pan;
  int         m_run;
  logic [15:0] m_value, m_stage;
  logic [3:0] m_blank, m_sblank, m_mask;
  bit         m_fv, m_err;

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (dig_tab[i] == p) return i;
    if (p == 7'h00) return 16;
    return -1;
  endfunction

  task automatic model_reset();
    ev_t none;
    none.valid = 1'b0; none.seg = 7'h00; none.an = 4'h0;
    m_q.delete();
    m_q.push_back(none);
    m_q.push_back(none);
    m_pseg = 7'h00; m_pan = 4'h0; m_run = 0;
    m_value = 16'h0; m_stage = 16'h0; m_blank = 4'h0; m_sblank = 4'h0;
    m_mask = 4'h0; m_fv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] seg, input logic [3:0] an);
    ev_t e, n;
    int d, idx;
    e = m_q.pop_front();
    m_fv = 1'b0;
    if (m_mask == 4'hF) begin
      m_value = m_stage; m_blank = m_sblank; m_fv = 1'b1; m_mask = 4'h0;
    end
    if (e.valid) begin
      d = decode(e.seg);
      if ($countones(e.an) != 1 || d < 0) m_err = 1'b1;
      else begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (e.an[i]) idx = i;
        m_stage[idx*4 +: 4] = (d == 16) ? 4'h0 : 4'(d);
        m_sblank[idx] = (d == 16);
        m_mask[idx] = 1'b1;
      end
    end
    if (an == 4'h0) m_run = 0;
    else if (seg == m_pseg && an == m_pan) m_run = m_run + 1;
    else m_run = 1;
    m_pseg = seg; m_pan = an;
    n.valid = (m_run == N); n.seg = seg; n.an = an;
    m_q.push_back(n);
  endtask

  task automatic tick(input logic [6:0] seg, input logic [3:0] an);
    @(negedge clk);
    segments = seg;
    anode = an;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(seg, an);
    #1;
    if (frame_valid === 1'b1) begin
      fvc++;
      fv_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic hold(input logic [6:0] seg, input logic [3:0] an, input int n);
    for (int i = 0; i < n; i++) tick(seg, an);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3, input int n);
    hold(p0, 4'b0001, n);
    hold(p1, 4'b0010, n);
    hold(p2, 4'b0100, n);
    hold(p3, 4'b1000, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(7'h00, 4'h0);
    tick(7'h00, 4'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h exp=0000", value); end
    checks++; if (blank_mask !== 4'h0) begin failures++; $display("FAIL reset_blank got=%h exp=0", blank_mask); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (pattern_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", pattern_err); end
  endtask

  task automatic test_scan();
    int start;
    do_reset();
    fvc = 0;
    start = cyc;
    scan(7'h79, 7'h5B, 7'h7E, 7'h30, 6);
    hold(7'h00, 4'h0, 3);
    checks++; if (fvc != 1) begin failures++; $display("FAIL scan_fv_count got=%0d exp=1", fvc); end
    // fourth capture lands on edge 23 of the scan, frame one edge later
    checks++; if (fv_cyc - start != 24) begin failures++; $display("FAIL scan_latency got=%0d exp=24", fv_cyc - start); end
    checks++; if (value !== 16'h1053) begin failures++; $display("FAIL scan_value got=%h exp=1053", value); end
    checks++; if (blank_mask !== 4'h0) begin failures++; $display("FAIL scan_blank got=%h exp=0", blank_mask); end
    checks++; if (pattern_err !== 1'b0) begin failures++; $display("FAIL scan_err got=%b exp=0", pattern_err); end
  endtask

  task automatic test_short_hold();
    do_reset();
    fvc = 0;
    hold(7'h30, 4'b0010, N - 1);
    hold(7'h00, 4'h0, 3);
    hold(7'h7E, 4'b0001, 6);
    hold(7'h7E, 4'b0100, 6);
    hold(7'h7E, 4'b1000, 6);
    hold(7'h00, 4'h0, 4);
    checks++; if (fvc != 0) begin failures++; $display("FAIL short_hold_fv got=%0d exp=0", fvc); end
    hold(7'h30, 4'b0010, 6);
    hold(7'h00, 4'h0, 3);
    checks++; if (fvc != 1) begin failures++; $display("FAIL short_hold_complete got=%0d exp=1", fvc); end
    checks++; if (value !== 16'h0010) begin failures++; $display("FAIL short_hold_value got=%h exp=0010", value); end
  endtask

  task automatic test_bad_pattern();
    do_reset();
    scan(7'h79, 7'h5B, 7'h7E, 7'h30, 6);
    hold(7'h00, 4'h0, 2);
    hold(7'h2A, 4'b0100, 4);
    hold(7'h00, 4'h0, 3);
    checks++; if (pattern_err !== 1'b1) begin failures++; $display("FAIL bad_pat_err got=%b exp=1", pattern_err); end
    hold(7'h00, 4'h0, 10);
    checks++; if (pattern_err !== 1'b1) begin failures++; $display("FAIL bad_pat_sticky got=%b exp=1", pattern_err); end
    checks++; if (value !== 16'h1053) begin failures++; $display("FAIL bad_pat_value got=%h exp=1053", value); end
  endtask

  task automatic test_multi_anode();
    do_reset();
    hold(7'h7E, 4'b0011, 4);
    hold(7'h00, 4'h0, 3);
    checks++; if (pattern_err !== 1'b1) begin failures++; $display("FAIL multi_anode_err got=%b exp=1", pattern_err); end
    do_reset();
    fvc = 0;
    for (int i = 0; i < 50; i++) tick(7'($urandom), 4'h0);
    checks++; if (pattern_err !== 1'b0) begin failures++; $display("FAIL anode_zero_err got=%b exp=0", pattern_err); end
    checks++; if (fvc != 0) begin failures++; $display("FAIL anode_zero_fv got=%0d exp=0", fvc); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    hold(7'h79, 4'b0001, 6);
    hold(7'h5B, 4'b0010, 6);
    hold(7'h7E, 4'b0100, 6);
    do_reset();
    fvc = 0;
    hold(7'h7F, 4'b1000, 6);
    hold(7'h00, 4'h0, 3);
    checks++; if (fvc != 0) begin failures++; $display("FAIL midframe_partial got=%0d exp=0", fvc); end
    scan(7'h7F, 7'h7F, 7'h7F, 7'h7F, 6);
    hold(7'h00, 4'h0, 3);
    checks++; if (fvc != 1) begin failures++; $display("FAIL midframe_fv got=%0d exp=1", fvc); end
    checks++; if (value !== 16'h8888) begin failures++; $display("FAIL midframe_value got=%h exp=8888", value); end
  endtask

  task automatic test_blank();
    do_reset();
    scan(7'h30, 7'h30, 7'h30, 7'h00, 6);
    hold(7'h00, 4'h0, 3);
    checks++; if (blank_mask !== 4'b1000) begin failures++; $display("FAIL blank_mask got=%b exp=1000", blank_mask); end
    checks++; if (value !== 16'h0111) begin failures++; $display("FAIL blank_value got=%h exp=0111", value); end
    checks++; if (pattern_err !== 1'b0) begin failures++; $display("FAIL blank_err got=%b exp=0", pattern_err); end
  endtask

  task automatic test_random();
    logic [6:0] seg;
    logic [3:0] an;
    int r, len;
    do_reset();
    for (int run = 0; run < 160; run++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      r = $urandom_range(0, 99);
      if (r < 8) an = 4'h0;
      else if (r < 11) begin
        an = 4'($urandom);
        if ($countones(an) <= 1) an = 4'b0101;
      end else an = 4'b0001 << $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 3) seg = 7'($urandom);
      else if (r < 12) seg = 7'h00;
      else seg = dig_tab[$urandom_range(0, 15)];
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        tick(seg, an);
        checks++; if (frame_valid !== m_fv) begin failures++; $display("FAIL rand_fv cyc=%0d got=%b exp=%b", cyc, frame_valid, m_fv); end
        checks++; if (value !== m_value) begin failures++; $display("FAIL rand_value cyc=%0d got=%h exp=%h", cyc, value, m_value); end
        checks++; if (blank_mask !== m_blank) begin failures++; $display("FAIL rand_blank cyc=%0d got=%b exp=%b", cyc, blank_mask, m_blank); end
        checks++; if (pattern_err !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, pattern_err, m_err); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_short_hold();
    test_bad_pattern();
    test_multi_anode();
    test_reset_midframe();
    test_blank();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
